// File: rtl/wb_writer_if.sv
// wb_writer_if: bundles the ALU result, mul/div handshake, scoreboard and
// register-file write-port signals of the writeback stage.
// The slave modport is the writer itself; master is the pipeline/decode side.
interface wb_writer_if;
   logic        alu_we;
   logic [3:0]  alu_wa;
   logic [15:0] alu_wd;
   logic        md_valid;
   logic        md_ready;
   logic [3:0]  md_rd;
   logic [15:0] md_lo;
   logic [15:0] md_hi;
   logic        md_issue;
   logic [3:0]  md_issue_rd;
   logic        RegWrite;
   logic [3:0]  WA1;
   logic [15:0] WD1;
   logic        R0W;
   logic [15:0] R0D;
   logic        wb_stall;
   logic [15:0] busy;

   modport master (
      output alu_we, alu_wa, alu_wd, md_valid, md_rd, md_lo, md_hi, md_issue, md_issue_rd,
      input  md_ready, RegWrite, WA1, WD1, R0W, R0D, wb_stall, busy
   );

   modport slave (
      input  alu_we, alu_wa, alu_wd, md_valid, md_rd, md_lo, md_hi, md_issue, md_issue_rd,
      output md_ready, RegWrite, WA1, WD1, R0W, R0D, wb_stall, busy
   );
endinterface

// File: rtl/wb_writer.sv
// wb_writer: writeback-stage driver for the general write port (RegWrite/WA1/WD1)
// and the dedicated R0 port (R0W/R0D). ALU results always win the slot; mul/div
// results queue in a FIFO and drain on idle ALU cycles. A starvation counter
// raises wb_stall so decode can open a slot for the FIFO head.
// Optional feature macro: WB_SCOREBOARD_EN enables the busy/outst scoreboard;
// when undefined busy is tied low and md_issue/md_issue_rd are ignored.
module wb_writer #(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_LIM = 4
) (
   input logic        clk,
   input logic        rst,
   wb_writer_if.slave bus
);

   localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AddrW:0] FullCnt = DEPTH[AddrW:0];
   localparam logic [3:0] StarveLim  = STARVE_LIM[3:0];

   typedef struct packed {
      logic [3:0]  rd;
      logic [15:0] lo;
      logic [15:0] hi;
   } md_entry_t;

   md_entry_t        r_mem [DEPTH];
   logic [AddrW-1:0] r_wptr;
   logic [AddrW-1:0] r_rptr;
   logic [AddrW:0]   r_count;
   logic [3:0]       r_age;
   logic             r_stall;
   logic             r_regwrite;
   logic [3:0]       r_wa1;
   logic [15:0]      r_wd1;
   logic             r_r0w;
   logic [15:0]      r_r0d;

   logic      w_full;
   logic      w_empty;
   logic      w_push;
   logic      w_pop;
   logic [3:0] w_age_d;
   md_entry_t w_head;
   md_entry_t w_in;

   assign w_full  = (r_count == FullCnt);
   assign w_empty = (r_count == '0);
   assign w_push  = bus.md_valid && !w_full;
   // Pop decision uses occupancy before this cycle's push: no fall-through.
   assign w_pop   = !bus.alu_we && !w_empty;
   assign w_head  = r_mem[r_rptr];
   assign w_in    = '{rd: bus.md_rd, lo: bus.md_lo, hi: bus.md_hi};

   assign bus.md_ready = !w_full;
   assign bus.RegWrite = r_regwrite;
   assign bus.WA1      = r_wa1;
   assign bus.WD1      = r_wd1;
   assign bus.R0W      = r_r0w;
   assign bus.R0D      = r_r0d;
   assign bus.wb_stall = r_stall;

   // FIFO storage; contents are don't-care while not counted, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_in;
      end
   end

   // FIFO pointers and occupancy; reset discards all queued results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Next age of the FIFO head; saturates so a long wait cannot wrap past the limit.
   always_comb begin
      w_age_d = r_age;
      if (w_empty || w_pop) begin
         w_age_d = 4'd0;
      end else if (r_age != 4'hF) begin
         w_age_d = r_age + 4'd1;
      end
   end

   // Age counter and stall flag move together, so wb_stall == (age >= limit).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_age   <= 4'd0;
         r_stall <= 1'b0;
      end else begin
         r_age   <= w_age_d;
         r_stall <= (w_age_d >= StarveLim);
      end
   end

   // Registered write ports: ALU first, otherwise drain the FIFO head.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_regwrite <= 1'b0;
         r_wa1      <= 4'd0;
         r_wd1      <= 16'd0;
         r_r0w      <= 1'b0;
         r_r0d      <= 16'd0;
      end else if (bus.alu_we) begin
         r_regwrite <= 1'b1;
         r_wa1      <= bus.alu_wa;
         r_wd1      <= bus.alu_wd;
         r_r0w      <= 1'b0;
      end else if (w_pop) begin
         r_r0w <= 1'b1;
         r_r0d <= w_head.hi;
         if (w_head.rd != 4'd0) begin
            r_regwrite <= 1'b1;
            r_wa1      <= w_head.rd;
            r_wd1      <= w_head.lo;
         end else begin
            // Low half aimed at R0 is dropped; R0 takes the high half.
            r_regwrite <= 1'b0;
         end
      end else begin
         r_regwrite <= 1'b0;
         r_r0w      <= 1'b0;
      end
   end

`ifdef WB_SCOREBOARD_EN
   logic [15:0] r_busy;
   logic [2:0]  r_outst;
   logic        r_clr_v;
   logic [3:0]  r_clr_rd;
   logic [15:0] w_set;
   logic [15:0] w_clr;

   assign w_set    = bus.md_issue ? (16'h0001 << bus.md_issue_rd) : 16'h0000;
   assign w_clr    = r_clr_v ? (16'h0001 << r_clr_rd) : 16'h0000;
   assign bus.busy = {r_busy[15:1], r_busy[0] | (r_outst != 3'd0)};

   // Delay the pop by one cycle so busy clears on the register-file commit edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_clr_v  <= 1'b0;
         r_clr_rd <= 4'd0;
      end else begin
         r_clr_v  <= w_pop;
         r_clr_rd <= w_head.rd;
      end
   end

   // Busy mask and outstanding count; a same-cycle set beats the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy  <= 16'h0000;
         r_outst <= 3'd0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
         unique case ({bus.md_issue, r_clr_v})
            2'b10:   r_outst <= r_outst + 3'd1;
            2'b01:   r_outst <= r_outst - 3'd1;
            default: r_outst <= r_outst;
         endcase
      end
   end
`else
   logic w_unused_sb;
   assign w_unused_sb = ^{bus.md_issue, bus.md_issue_rd};
   assign bus.busy    = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed bench for wb_writer with a write-port scoreboard.
// Expected ALU and mul/div writes are queued when driven and checked when the
// DUT pulses RegWrite/R0W; level checks cover md_ready, wb_stall, busy and reset.
module tb_wb_writer;

   typedef struct {
      logic [3:0]  wa;
      logic [15:0] wd;
   } alu_t;

   typedef struct {
      logic [3:0]  rd;
      logic [15:0] lo;
      logic [15:0] hi;
   } md_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   alu_t alu_q[$];
   md_t  md_q[$];
   logic [3:0]  m_wa;
   logic [15:0] m_wd;
   logic [15:0] m_r0d;

   wb_writer_if u_if ();

   wb_writer #(
      .DEPTH      (2),
      .STARVE_LIM (4)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_alu(input logic [3:0] wa, input logic [15:0] wd);
      alu_t a;
      a.wa = wa;
      a.wd = wd;
      u_if.alu_we = 1'b1;
      u_if.alu_wa = wa;
      u_if.alu_wd = wd;
      alu_q.push_back(a);
   endtask

   task automatic set_md(input logic [3:0] rd, input logic [15:0] lo, input logic [15:0] hi);
      md_t e;
      e.rd = rd;
      e.lo = lo;
      e.hi = hi;
      chk("md_ready before push", 32'(u_if.md_ready), 1);
      u_if.md_valid = 1'b1;
      u_if.md_rd    = rd;
      u_if.md_lo    = lo;
      u_if.md_hi    = hi;
      md_q.push_back(e);
   endtask

   task automatic set_issue(input logic [3:0] rd);
      u_if.md_issue    = 1'b1;
      u_if.md_issue_rd = rd;
   endtask

   // One clock: sample #1 after the edge, score any write pulse, clear pulses.
   task automatic tick();
      md_t  e;
      alu_t a;
      @(posedge clk);
      #1;
      if (u_if.R0W === 1'b1) begin
         chk("md write expected", 32'(md_q.size() != 0), 1);
         if (md_q.size() != 0) begin
            e = md_q.pop_front();
            if (e.rd != 4'd0) begin
               m_wa = e.rd;
               m_wd = e.lo;
            end
            m_r0d = e.hi;
            chk("md RegWrite", 32'(u_if.RegWrite), 32'(e.rd != 4'd0));
            chk("md WA1", 32'(u_if.WA1), 32'(m_wa));
            chk("md WD1", 32'(u_if.WD1), 32'(m_wd));
            chk("md R0D", 32'(u_if.R0D), 32'(m_r0d));
         end
      end else if (u_if.RegWrite === 1'b1) begin
         chk("alu write expected", 32'(alu_q.size() != 0), 1);
         if (alu_q.size() != 0) begin
            a = alu_q.pop_front();
            m_wa = a.wa;
            m_wd = a.wd;
            chk("alu WA1", 32'(u_if.WA1), 32'(m_wa));
            chk("alu WD1", 32'(u_if.WD1), 32'(m_wd));
            chk("alu R0D held", 32'(u_if.R0D), 32'(m_r0d));
         end
      end
      u_if.alu_we   = 1'b0;
      u_if.md_valid = 1'b0;
      u_if.md_issue = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " RegWrite"}, 32'(u_if.RegWrite), 0);
      chk({tag, " WA1"}, 32'(u_if.WA1), 0);
      chk({tag, " WD1"}, 32'(u_if.WD1), 0);
      chk({tag, " R0W"}, 32'(u_if.R0W), 0);
      chk({tag, " R0D"}, 32'(u_if.R0D), 0);
      chk({tag, " wb_stall"}, 32'(u_if.wb_stall), 0);
      chk({tag, " busy"}, 32'(u_if.busy), 0);
      chk({tag, " md_ready"}, 32'(u_if.md_ready), 1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_wa        = 4'd0;
      m_wd        = 16'd0;
      m_r0d       = 16'd0;
      rst              = 1'b0;
      u_if.alu_we      = 1'b0;
      u_if.alu_wa      = 4'd0;
      u_if.alu_wd      = 16'd0;
      u_if.md_valid    = 1'b0;
      u_if.md_rd       = 4'd0;
      u_if.md_lo       = 16'd0;
      u_if.md_hi       = 16'd0;
      u_if.md_issue    = 1'b0;
      u_if.md_issue_rd = 4'd0;

      #2;
      chk_reset_state("reset");
      @(negedge clk);
      rst = 1'b1;

      // ALU only
      set_alu(4'd3, 16'h1234);
      tick();
      chk("alu RegWrite", 32'(u_if.RegWrite), 1);
      chk("alu R0W", 32'(u_if.R0W), 0);
      chk("alu drained", 32'(alu_q.size()), 0);

      // Mul/div with idle ALU: visible two cycles after the push
      set_md(4'd5, 16'h0040, 16'h0001);
      tick();
      chk("md no fall-through", 32'(u_if.R0W), 0);
      tick();
      chk("md R0W", 32'(u_if.R0W), 1);
      chk("md drained", 32'(md_q.size()), 0);

      // rd=0: only R0 written
      set_md(4'd0, 16'hAAAA, 16'h5555);
      tick();
      tick();
      chk("rd0 R0W", 32'(u_if.R0W), 1);
      chk("rd0 R0D", 32'(u_if.R0D), 32'h5555);
      chk("rd0 drained", 32'(md_q.size()), 0);

      // Full FIFO, starvation and in-order drain
      set_alu(4'd1, 16'h1111);
      set_md(4'd2, 16'h2222, 16'h2020);
      tick();
      set_alu(4'd4, 16'h4444);
      set_md(4'd6, 16'h6666, 16'h6060);
      tick();
      chk("full md_ready", 32'(u_if.md_ready), 0);
      chk("stall age1", 32'(u_if.wb_stall), 0);
      for (int i = 0; i < 2; i++) begin
         set_alu(4'(8 + i), 16'h8000 + 16'(i));
         tick();
         chk("stall below limit", 32'(u_if.wb_stall), 0);
      end
      set_alu(4'd10, 16'hA0A0);
      tick();
      chk("stall at limit", 32'(u_if.wb_stall), 1);
      chk("still full", 32'(u_if.md_ready), 0);
      tick();
      chk("first pop R0W", 32'(u_if.R0W), 1);
      chk("ready after pop", 32'(u_if.md_ready), 1);
      chk("stall cleared", 32'(u_if.wb_stall), 0);
      tick();
      chk("second pop R0W", 32'(u_if.R0W), 1);
      chk("drain md_q", 32'(md_q.size()), 0);
      chk("drain alu_q", 32'(alu_q.size()), 0);

`ifdef WB_SCOREBOARD_EN
      // Scoreboard set, commit-edge clear, and set beating a same-edge clear
      set_issue(4'd7);
      tick();
      chk("busy issue 7", 32'(u_if.busy), 32'h0081);
      set_md(4'd7, 16'h0707, 16'h7070);
      tick();
      tick();
      chk("busy at pop output", 32'(u_if.busy), 32'h0081);
      tick();
      chk("busy after commit", 32'(u_if.busy), 32'h0000);
      set_issue(4'd7);
      tick();
      set_md(4'd7, 16'h0777, 16'h7700);
      tick();
      tick();
      set_issue(4'd9);
      tick();
      chk("busy issue 9 with pop 7", 32'(u_if.busy), 32'h0201);
      tick();
      chk("busy 9 holds", 32'(u_if.busy), 32'h0201);
      set_md(4'd9, 16'h0999, 16'h9900);
      tick();
      tick();
      tick();
      chk("busy all clear", 32'(u_if.busy), 32'h0000);
`else
      set_issue(4'd7);
      tick();
      chk("busy tied low", 32'(u_if.busy), 32'h0000);
`endif

      // Reset with two queued entries and wb_stall raised
      set_alu(4'd1, 16'h0101);
      set_md(4'd2, 16'h0202, 16'h2020);
      tick();
      set_alu(4'd1, 16'h0102);
      set_md(4'd3, 16'h0303, 16'h3030);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_alu(4'd1, 16'h0110 + 16'(i));
         tick();
      end
      chk("pre-reset stall", 32'(u_if.wb_stall), 1);
      chk("pre-reset RegWrite", 32'(u_if.RegWrite), 1);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_state("mid reset");
      md_q.delete();
      m_wa  = 4'd0;
      m_wd  = 16'd0;
      m_r0d = 16'd0;
      tick();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post-reset RegWrite", 32'(u_if.RegWrite), 0);
         chk("post-reset R0W", 32'(u_if.R0W), 0);
      end

      // Normal ALU write after reset
      set_alu(4'd12, 16'hC0DE);
      tick();
      chk("post-reset alu", 32'(u_if.RegWrite), 1);
      chk("final alu_q", 32'(alu_q.size()), 0);
      chk("final md_q", 32'(md_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
